serial_fa_adder: RTL and testbench

//  Bit-serial adder wrapped around a single FA cell (ports A,B,Cin,S,Cout), instantiated once.
//  - Operand stage feeding the FA cell: accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
//  - Streams the operands LSB-first through the cell, one bit per clock, holding the carry in a flop.
//  - Presents the WIDTH-bit sum and carry-out on an output valid/ready handshake.
//  - Area-cheap alternative to the ripple-carry adder; same result, WIDTH cycles per add.

---
 rtl/serial_fa_adder.sv | 159 +++++++++++++++
 tb/tb_serial_fa_adder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_fa_adder.sv
// Bit-serial adder built around a single full-adder cell.
// Operands are accepted on a valid/ready handshake and shifted LSB-first
// through the cell, one bit per clock, with the carry held in a flop.
// The WIDTH-bit sum and carry-out are then offered on an output handshake.

module fa_cell (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_fa_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    // count must be able to hold WIDTH itself, hence WIDTH+1
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shift;
    logic             cy;
    logic [CW-1:0]    count;
    logic             fa_s;
    logic             fa_cout;

    // The one and only adder cell: low bits of the operand shifters plus held carry
    fa_cell u_fa (
        .A    (ra[0]),
        .B    (rb[0]),
        .Cin  (cy),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // Next-state logic; result leaves DONE only on a real output handshake
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    next_state = ST_SHIFT;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (count == LAST) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_valid && out_ready) begin
                    next_state = ST_IDLE;
                end else begin
                    next_state = ST_DONE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB
    always_comb begin
        sr_shift            = sr >> 1;
        sr_shift[WIDTH-1]   = fa_s;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operand capture and serial datapath; inputs are only looked at on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra    <= {WIDTH{1'b0}};
            rb    <= {WIDTH{1'b0}};
            sr    <= {WIDTH{1'b0}};
            cy    <= 1'b0;
            count <= {CW{1'b0}};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        ra    <= a;
                        rb    <= b;
                        cy    <= cin;
                        count <= {CW{1'b0}};
                    end
                end
                ST_SHIFT: begin
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    sr    <= sr_shift;
                    cy    <= fa_cout;
                    count <= count + CW'(1);
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

    // Registered handshake/status outputs; result is published one cycle into DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            sum       <= {WIDTH{1'b0}};
            cout      <= 1'b0;
        end else begin
            in_ready  <= (next_state == ST_IDLE);
            busy      <= (next_state != ST_IDLE);
            out_valid <= (state == ST_DONE) && !(out_valid && out_ready);
            if (state == ST_DONE) begin
                sum  <= sr;
                cout <= cy;
            end
        end
    end
endmodule

// File: tb/tb_serial_fa_adder.sv
// Self-checking bench for serial_fa_adder: a WIDTH=8 and a WIDTH=1 instance
// are checked every cycle against a transaction-level timing/arithmetic model,
// plus directed vectors with hand-computed results.

module tb_serial_fa_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [1:0]  cin;
    logic [1:0]  cout;
    logic [1:0]  busy;
    logic [7:0]  a8, b8, sum8;
    logic [0:0]  a1, b1, sum1;

    int tests = 0;
    int fails = 0;

    // model state per instance (0: WIDTH=8, 1: WIDTH=1)
    logic        m_pend[2];
    int          m_age[2];
    logic [63:0] m_esum[2];
    logic        m_ecout[2];
    int          m_acc[2] = '{0, 0};
    int          m_del[2] = '{0, 0};

    always #5 clk = ~clk;

    serial_fa_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a8), .b(b8), .cin(cin[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .sum(sum8), .cout(cout[0]), .busy(busy[0])
    );

    serial_fa_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a1), .b(b1), .cin(cin[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .sum(sum1), .cout(cout[1]), .busy(busy[1])
    );

    function automatic int wid(int i);
        return (i == 0) ? 8 : 1;
    endfunction

    function automatic logic [64:0] total(int i);
        logic [64:0] opa;
        logic [64:0] opb;
        opa = (i == 0) ? 65'(a8) : 65'(a1);
        opb = (i == 0) ? 65'(b8) : 65'(b1);
        return opa + opb + 65'(cin[i]);
    endfunction

    // Transaction model: one op in flight, result due WIDTH+1 edges after acceptance
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_pend[i]  <= 1'b0;
                m_age[i]   <= 0;
                m_esum[i]  <= 64'd0;
                m_ecout[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!m_pend[i]) begin
                    if (in_valid[i]) begin
                        m_pend[i]  <= 1'b1;
                        m_age[i]   <= 0;
                        m_esum[i]  <= 64'(total(i) & ((65'd1 << wid(i)) - 65'd1));
                        m_ecout[i] <= total(i)[wid(i)];
                        m_acc[i]   <= m_acc[i] + 1;
                    end
                end else if (m_age[i] >= wid(i) + 1 && out_ready[i]) begin
                    m_pend[i] <= 1'b0;
                    m_del[i]  <= m_del[i] + 1;
                end else begin
                    m_age[i] <= m_age[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison of both DUTs against the model
    task automatic compare();
        logic        exp_ov;
        logic [63:0] s;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                exp_ov = m_pend[i] && (m_age[i] >= wid(i) + 1);
                s = (i == 0) ? 64'(sum8) : 64'(sum1);
                chk($sformatf("in_ready[%0d]", i), 64'(in_ready[i]), 64'(!m_pend[i]));
                chk($sformatf("busy[%0d]", i), 64'(busy[i]), 64'(m_pend[i]));
                chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(exp_ov));
                if (exp_ov) begin
                    chk($sformatf("sum[%0d]", i), s, m_esum[i]);
                    chk($sformatf("cout[%0d]", i), 64'(cout[i]), 64'(m_ecout[i]));
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input int i, input logic [7:0] va, input logic [7:0] vb, input logic vc);
        if (i == 0) begin
            a8 = va;
            b8 = vb;
        end else begin
            a1 = va[0:0];
            b1 = vb[0:0];
        end
        cin[i] = vc;
    endtask

    // issue one op on instance i, return at the first cycle out_valid is seen
    task automatic run_op(input int i, input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input logic [7:0] es, input logic ec, input int lat);
        int          n;
        logic [63:0] s;
        drive(i, va, vb, vc);
        in_valid[i] = 1'b1;
        tick();
        in_valid[i] = 1'b0;
        drive(i, ~va, ~vb, ~vc);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n = k;
            if (out_valid[i]) break;
        end
        if (!out_valid[i]) n = 99;
        s = (i == 0) ? 64'(sum8) : 64'(sum1);
        chk($sformatf("latency[%0d]", i), 64'(n), 64'(lat));
        chk($sformatf("lit_sum[%0d]", i), s, 64'(es));
        chk($sformatf("lit_cout[%0d]", i), 64'(cout[i]), 64'(ec));
    endtask

    initial begin
        int acc0, del0, acc1, del1, cyc;
        rst       = 1'b1;
        in_valid  = 2'b00;
        out_ready = 2'b00;
        cin       = 2'b00;
        a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // reset values
        chk("rst_in_ready", 64'(in_ready), 64'(2'b11));
        chk("rst_out_valid", 64'(out_valid), 64'(2'b00));
        chk("rst_busy", 64'(busy), 64'(2'b00));
        chk("rst_sum8", 64'(sum8), 64'h0);
        chk("rst_cout", 64'(cout), 64'(2'b00));
        rst = 1'b0;
        tick();

        // basic add, then full carry ripple
        out_ready = 2'b11;
        run_op(0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 9);
        tick();
        run_op(0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 9);
        tick();
        run_op(0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 9);
        tick();

        // backpressure: result held, new operands ignored
        out_ready[0] = 1'b0;
        run_op(0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 9);
        for (int k = 0; k < 5; k++) begin
            in_valid[0] = 1'b1;
            drive(0, 8'hEE, 8'hEE, 1'b1);
            tick();
            chk("bp_sum", 64'(sum8), 64'h47);
            chk("bp_in_ready", 64'(in_ready[0]), 64'h0);
            chk("bp_out_valid", 64'(out_valid[0]), 64'h1);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        chk("bp_release_in_ready", 64'(in_ready[0]), 64'h1);
        chk("bp_release_out_valid", 64'(out_valid[0]), 64'h0);

        // reset at count=3 of an add
        drive(0, 8'hAA, 8'h55, 1'b0);
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid[0]), 64'h0);
        chk("abort_in_ready", 64'(in_ready[0]), 64'h1);
        chk("abort_sum", 64'(sum8), 64'h0);
        chk("abort_busy", 64'(busy[0]), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_op(0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 9);
        tick();

        // WIDTH=1 instance
        run_op(1, 8'h01, 8'h01, 1'b1, 8'h01, 1'b1, 2);
        tick();
        run_op(1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 2);
        tick();

        // random back-to-back sweep on both instances
        acc0 = m_acc[0]; del0 = m_del[0];
        acc1 = m_acc[1]; del1 = m_del[1];
        cyc = 0;
        while ((m_acc[0] - acc0) < 1000 && cyc < 40000) begin
            in_valid  = 2'($urandom_range(3));
            out_ready = 2'($urandom_range(3));
            a8 = 8'($urandom_range(255));
            b8 = 8'($urandom_range(255));
            a1 = 1'($urandom_range(1));
            b1 = 1'($urandom_range(1));
            cin = 2'($urandom_range(3));
            tick();
            cyc++;
        end
        in_valid  = 2'b00;
        out_ready = 2'b11;
        for (int k = 0; k < 20; k++) tick();
        chk("sweep_ops_done", 64'((m_acc[0] - acc0) >= 1000), 64'h1);
        chk("sweep_no_loss0", 64'(m_del[0] - del0), 64'(m_acc[0] - acc0));
        chk("sweep_no_loss1", 64'(m_del[1] - del1), 64'(m_acc[1] - acc1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
